// File: rtl/systolic_pe_if.sv
// systolic_pe_if: beat bus of one systolic MAC processing element.
// Signals (all named from the PE's point of view):
//   valid_in, a_in, b_in, ps_in          - incoming beat (west/north/partial sum)
//   valid_out, a_out, b_out, ps_out, ovf_out - registered outgoing beat
// Modports: master drives the incoming beat and observes results; slave is the PE.
interface systolic_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] b_in;
    logic signed [ACC_W-1:0]  ps_in;
    logic                     valid_out;
    logic signed [DATA_W-1:0] a_out;
    logic signed [DATA_W-1:0] b_out;
    logic signed [ACC_W-1:0]  ps_out;
    logic                     ovf_out;

    modport master (
        output valid_in, a_in, b_in, ps_in,
        input  valid_out, a_out, b_out, ps_out, ovf_out
    );

    modport slave (
        input  valid_in, a_in, b_in, ps_in,
        output valid_out, a_out, b_out, ps_out, ovf_out
    );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe: signed multiply-accumulate PE, ps_out = ps_in + a_in*b_in, 1-cycle latency.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears every output register
//   bus - systolic_pe_if.slave: valid_in/a_in/b_in/ps_in in, valid_out/a_out/b_out/ps_out/ovf_out out
// Optional build macro SYSTOLIC_PE_SATURATE_EN: clamp ps_out on overflow instead of wrapping.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input logic          clk,
    input logic          rst,
    systolic_pe_if.slave bus
);
    if (ACC_W < 2 * DATA_W) begin : g_bad_width
        $error("systolic_pe: ACC_W must be >= 2*DATA_W");
    end

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      sum;
    logic                       ovf;
    logic signed [ACC_W-1:0]    res;

    // Full-width signed product never overflows; only the ACC_W add can.
    assign prod = bus.a_in * bus.b_in;
    assign sum  = {bus.ps_in[ACC_W-1], bus.ps_in}
                + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // Top two bits of the one-bit-wider sum disagree exactly when it left the ACC_W range.
    assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef SYSTOLIC_PE_SATURATE_EN
    assign res = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
`else
    assign res = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.ps_out    <= '0;
            bus.ovf_out   <= 1'b0;
        end else if (bus.valid_in) begin
            bus.valid_out <= 1'b1;
            bus.a_out     <= bus.a_in;
            bus.b_out     <= bus.b_in;
            bus.ps_out    <= res;
            bus.ovf_out   <= ovf;
        end else begin
            bus.valid_out <= 1'b0;
            bus.ovf_out   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_systolic_pe.sv
// tb_systolic_pe: directed vector table plus randomised model comparison for systolic_pe.
module tb_systolic_pe;
    localparam logic signed [31:0] MAX32 = 32'sh7fffffff;
    localparam logic signed [31:0] MIN32 = 32'sh80000000;
`ifdef SYSTOLIC_PE_SATURATE_EN
    localparam logic signed [31:0] POS_OVF_PS = MAX32;
    localparam logic signed [31:0] NEG_OVF_PS = MIN32;
`else
    localparam logic signed [31:0] POS_OVF_PS = MIN32;
    localparam logic signed [31:0] NEG_OVF_PS = MAX32;
`endif

    typedef struct {
        logic              rst;
        logic              vld;
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic signed [31:0] ps;
        logic              e_vld;
        logic signed [7:0] e_a;
        logic signed [7:0] e_b;
        logic signed [31:0] e_ps;
        logic              e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    vec_t vec[18];

    always #5 clk = ~clk;

    systolic_pe_if #(.DATA_W(8), .ACC_W(32)) bus ();
    systolic_pe #(.DATA_W(8), .ACC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string name, input int idx, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic signed [7:0] a,
                         input logic signed [7:0] b, input logic signed [31:0] ps);
        rst = r;
        bus.valid_in = v;
        bus.a_in = a;
        bus.b_in = b;
        bus.ps_in = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic ev, input logic signed [7:0] ea,
                             input logic signed [7:0] eb, input logic signed [31:0] eps,
                             input logic eo);
        check("valid_out", idx, {31'b0, bus.valid_out}, {31'b0, ev});
        check("a_out", idx, bus.a_out, ea);
        check("b_out", idx, bus.b_out, eb);
        check("ps_out", idx, bus.ps_out, eps);
        check("ovf_out", idx, {31'b0, bus.ovf_out}, {31'b0, eo});
    endtask

    initial begin
        logic              m_v, m_o, r, v;
        logic signed [7:0] m_a, m_b, ra, rb;
        logic signed [31:0] m_ps, rps;
        longint            s;

        // rst vld a b ps | e_vld e_a e_b e_ps e_ovf
        vec[0]  = '{1, 1, 9, 9, 9,              0, 0, 0, 0, 0};
        vec[1]  = '{1, 0, 0, 0, 0,              0, 0, 0, 0, 0};
        vec[2]  = '{0, 0, 7, 7, 7,              0, 0, 0, 0, 0};
        vec[3]  = '{0, 1, 3, 4, 10,             1, 3, 4, 22, 0};
        vec[4]  = '{0, 0, 0, 0, 0,              0, 3, 4, 22, 0};
        vec[5]  = '{0, 1, -3, 4, 5,             1, -3, 4, -7, 0};
        vec[6]  = '{0, 1, -128, -128, 0,        1, -128, -128, 16384, 0};
        vec[7]  = '{0, 1, 127, -128, -1,        1, 127, -128, -16257, 0};
        vec[8]  = '{0, 1, 1, 1, MAX32,          1, 1, 1, POS_OVF_PS, 1};
        vec[9]  = '{0, 1, -1, 1, MIN32,         1, -1, 1, NEG_OVF_PS, 1};
        vec[10] = '{0, 0, 50, 50, 50,           0, -1, 1, NEG_OVF_PS, 0};
        vec[11] = '{1, 1, 5, 5, 1,              0, 0, 0, 0, 0};
        vec[12] = '{0, 1, 2, 7, 0,              1, 2, 7, 14, 0};
        vec[13] = '{0, 0, -91, 33, 123456,      0, 2, 7, 14, 0};
        vec[14] = '{0, 0, 127, -128, MAX32,     0, 2, 7, 14, 0};
        vec[15] = '{0, 0, 17, 0, -5,            0, 2, 7, 14, 0};
        vec[16] = '{0, 0, -1, -1, MIN32,        0, 2, 7, 14, 0};
        vec[17] = '{0, 0, 64, 99, 777,          0, 2, 7, 14, 0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            drive(vec[i].rst, vec[i].vld, vec[i].a, vec[i].b, vec[i].ps);
            check_all(i, vec[i].e_vld, vec[i].e_a, vec[i].e_b, vec[i].e_ps, vec[i].e_ovf);
        end

        m_v = 0; m_a = 2; m_b = 7; m_ps = 14; m_o = 0;
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 49) == 0);
            v = $urandom_range(0, 1) == 1;
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 3))
                0: rps = MAX32 - 32'($urandom_range(0, 20000));
                1: rps = MIN32 + 32'($urandom_range(0, 20000));
                default: rps = 32'($urandom);
            endcase
            drive(r, v, ra, rb, rps);
            if (r) begin
                m_v = 0; m_a = 0; m_b = 0; m_ps = 0; m_o = 0;
            end else if (v) begin
                s = longint'(rps) + longint'(ra) * longint'(rb);
                m_v = 1; m_a = ra; m_b = rb;
                m_o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef SYSTOLIC_PE_SATURATE_EN
                m_ps = m_o ? (s > 0 ? MAX32 : MIN32) : s[31:0];
`else
                m_ps = s[31:0];
`endif
            end else begin
                m_v = 0; m_o = 0;
            end
            check_all(100 + i, m_v, m_a, m_b, m_ps, m_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
